// File: rtl/panda_pkg.sv
// Shared types and defaults for the panda core memory-side blocks.
package panda_pkg;

  typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_e;
  typedef enum logic {OWN_INSTR, OWN_DATA} arb_owner_e;

  localparam int ARB_STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/panda_arb_starve_cnt.sv
// Saturating wait counter for the instruction port of panda_mem_arbiter.
module panda_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic             o_sat,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  assign o_sat = (r_cnt == CNT_W'(STARVE_LIMIT));
  assign o_cnt = r_cnt;

  // Clear has priority so a grant in the same cycle as a wait never counts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/panda_mem_arbiter.sv
// Fetch/data arbiter onto one req/gnt/rvalid bus, one transaction in flight.
// Optional perf counters are enabled with the PANDA_ARB_PERF_EN macro.
module panda_mem_arbiter
  import panda_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_we_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
`ifdef PANDA_ARB_PERF_EN
  ,
  output logic [31:0] perf_instr_cnt_o,
  output logic [31:0] perf_data_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e       r_state, w_state_next;
  logic             r_locked, w_locked_next;
  arb_owner_e       r_lock_owner, w_lock_owner_next;
  arb_owner_e       r_resp_owner, w_resp_owner_next;
  arb_owner_e       w_winner;
  logic             r_armed;
  logic             w_out_en;
  logic             w_starve_sat;
  logic [CNT_W-1:0] w_starve_cnt;

  // Outputs stay quiet during reset and for the first cycle after it.
  assign w_out_en = !rst_i && r_armed;

  panda_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_inc (instr_req_i && !instr_gnt_o),
    .i_clr (!instr_req_i || instr_gnt_o),
    .o_sat (w_starve_sat),
    .o_cnt (w_starve_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ARB_IDLE;
      r_locked     <= 1'b0;
      r_lock_owner <= OWN_DATA;
      r_resp_owner <= OWN_DATA;
      r_armed      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_locked     <= w_locked_next;
      r_lock_owner <= w_lock_owner_next;
      r_resp_owner <= w_resp_owner_next;
      r_armed      <= 1'b1;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_locked_next     = r_locked;
    w_lock_owner_next = r_lock_owner;
    w_resp_owner_next = r_resp_owner;
    bus_req_o         = 1'b0;
    bus_addr_o        = 32'd0;
    bus_we_o          = 4'd0;
    bus_wdata_o       = 32'd0;
    instr_gnt_o       = 1'b0;
    data_gnt_o        = 1'b0;
    instr_rvalid_o    = 1'b0;
    instr_rdata_o     = 32'd0;
    data_rvalid_o     = 1'b0;
    data_rdata_o      = 32'd0;

    if (r_locked) begin
      w_winner = r_lock_owner;
    end else if (instr_req_i && (!data_req_i || w_starve_sat)) begin
      w_winner = OWN_INSTR;
    end else begin
      w_winner = OWN_DATA;
    end

    case (r_state)
      ARB_IDLE: begin
        if (w_out_en) begin
          if (w_winner == OWN_INSTR) begin
            bus_req_o   = instr_req_i;
            instr_gnt_o = instr_req_i && bus_gnt_i;
            if (instr_req_i) begin
              bus_addr_o = instr_addr_i;
            end
          end else begin
            bus_req_o  = data_req_i;
            data_gnt_o = data_req_i && bus_gnt_i;
            if (data_req_i) begin
              bus_addr_o  = data_addr_i;
              bus_we_o    = data_we_i;
              bus_wdata_o = data_wdata_i;
            end
          end
          // A stalled request pins the owner until the bus accepts it.
          if (bus_req_o && !bus_gnt_i) begin
            w_locked_next     = 1'b1;
            w_lock_owner_next = w_winner;
          end else if (bus_req_o && bus_gnt_i) begin
            w_locked_next     = 1'b0;
            w_resp_owner_next = w_winner;
            w_state_next      = ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        if (bus_rvalid_i) begin
          if (r_resp_owner == OWN_INSTR) begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = bus_rdata_i;
          end else begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = bus_rdata_i;
          end
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

`ifdef PANDA_ARB_PERF_EN
  logic [31:0] r_perf_instr, r_perf_data, r_perf_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_instr <= 32'd0;
      r_perf_data  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (instr_gnt_o) r_perf_instr <= r_perf_instr + 32'd1;
      if (data_gnt_o)  r_perf_data  <= r_perf_data + 32'd1;
      if ((instr_req_i && !instr_gnt_o) || (data_req_i && !data_gnt_o)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_instr_cnt_o = r_perf_instr;
  assign perf_data_cnt_o  = r_perf_data;
  assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// Scoreboard bench for panda_mem_arbiter: directed scenarios plus randomized traffic.
module tb_panda_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = 32'd0;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = 32'd0;
  logic [3:0]  data_we_i = 4'd0;
  logic [31:0] data_wdata_i = 32'd0;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_we_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'd0;
`ifdef PANDA_ARB_PERF_EN
  logic [31:0] perf_instr_cnt_o, perf_data_cnt_o, perf_stall_cnt_o;
`endif

  panda_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
`ifdef PANDA_ARB_PERF_EN
    , .perf_instr_cnt_o(perf_instr_cnt_o), .perf_data_cnt_o(perf_data_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  logic [31:0] ref_mem[64];
  logic [31:0] bus_mem[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Response monitor: every rvalid must match the oldest expectation for that port.
  always @(negedge clk_i) begin
    logic [31:0] e;
    if (instr_rvalid_o && data_rvalid_o) chk("both_rvalid", 32'd1, 32'd0);
    if (instr_rvalid_o) begin
      if (exp_i.size() == 0) chk("instr_unexpected_rvalid", instr_rdata_o, 32'hxxxxxxxx);
      else begin e = exp_i.pop_front(); chk("instr_rdata", instr_rdata_o, e); end
    end else if (instr_rdata_o !== 32'd0) chk("instr_rdata_idle", instr_rdata_o, 32'd0);
    if (data_rvalid_o) begin
      if (exp_d.size() == 0) chk("data_unexpected_rvalid", data_rdata_o, 32'hxxxxxxxx);
      else begin e = exp_d.pop_front(); chk("data_rdata", data_rdata_o, e); end
    end else if (data_rdata_o !== 32'd0) chk("data_rdata_idle", data_rdata_o, 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_inputs();
    instr_req_i = 0; data_req_i = 0; data_we_i = 0; data_wdata_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
  endtask

  function automatic logic [31:0] outs_vec();
    return {27'd0, bus_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o};
  endfunction

  task automatic do_reset();
    clear_inputs();
    rst_i = 1;
    step(); step();
    @(negedge clk_i);
    chk("reset_outs", outs_vec(), 32'd0);
    step();
    rst_i = 0;
    @(negedge clk_i);
    chk("post_reset_outs", outs_vec(), 32'd0);
    step();
  endtask

  task automatic txn(input bit is_instr, input logic [31:0] addr, input logic [3:0] we,
                     input logic [31:0] wd, input logic [31:0] rd);
    if (is_instr) begin instr_req_i = 1; instr_addr_i = addr; end
    else begin data_req_i = 1; data_addr_i = addr; data_we_i = we; data_wdata_i = wd; end
    bus_gnt_i = 1;
    @(negedge clk_i);
    chk(is_instr ? "txn_instr_gnt" : "txn_data_gnt", is_instr ? 32'(instr_gnt_o) : 32'(data_gnt_o), 32'd1);
    chk("txn_bus_addr", bus_addr_o, addr);
    if (is_instr) exp_i.push_back(rd); else exp_d.push_back(rd);
    step();
    instr_req_i = 0; data_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = rd;
    @(negedge clk_i);
    step();
    bus_rvalid_i = 0; bus_rdata_i = 0;
  endtask

  initial begin
    int arbs;
    bit got, pend, gi, gd, raise, bpend;
    int bdly;
    logic [31:0] bdata;
    logic [5:0] idx;

    do_reset();

    // Single fetch, zero-cycle issue, response one cycle later.
    txn(1, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF);

    // Simultaneous requests: data wins.
    instr_req_i = 1; instr_addr_i = 32'h300;
    data_req_i = 1; data_addr_i = 32'h200; data_we_i = 4'hF; data_wdata_i = 32'h12345678;
    bus_gnt_i = 1;
    @(negedge clk_i);
    chk("both_bus_addr", bus_addr_o, 32'h200);
    chk("both_bus_we", 32'(bus_we_o), 32'hF);
    chk("both_bus_wdata", bus_wdata_o, 32'h12345678);
    chk("both_data_gnt", 32'(data_gnt_o), 32'd1);
    chk("both_instr_gnt", 32'(instr_gnt_o), 32'd0);
    exp_d.push_back(32'h0);
    step();
    instr_req_i = 0; data_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 0;
    @(negedge clk_i);
    step();
    clear_inputs();
    step();

    // Starvation: data held, instr held, bus always grants, rvalid next cycle.
    data_req_i = 1; data_addr_i = 32'h700; data_we_i = 0;
    instr_req_i = 1; instr_addr_i = 32'h800; bus_gnt_i = 1; bus_rdata_i = 32'hCAFE0003;
    arbs = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk_i);
      if (bus_req_o) arbs++;
      if (data_gnt_o) exp_d.push_back(32'hCAFE0003);
      if (instr_gnt_o) begin exp_i.push_back(32'hCAFE0003); got = 1; end
      pend = data_gnt_o || instr_gnt_o;
      step();
      bus_rvalid_i = pend;
      if (got) instr_req_i = 0;
    end
    chk("starve_granted", 32'(got), 32'd1);
    chk("starve_arbitrations", 32'(arbs), 32'd3);
    @(negedge clk_i);
    chk("starve_cnt_cleared", 32'(dut.w_starve_cnt), 32'd0);
    step();
    clear_inputs();
    step();

    // Lock: instr stalls on the bus, data rises meanwhile and must wait.
    instr_req_i = 1; instr_addr_i = 32'h400;
    @(negedge clk_i);
    chk("lock_bus_req", 32'(bus_req_o), 32'd1);
    chk("lock_addr_c0", bus_addr_o, 32'h400);
    step();
    data_req_i = 1; data_addr_i = 32'h500; data_we_i = 0;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk_i);
      chk("lock_addr_hold", bus_addr_o, 32'h400);
      chk("lock_data_gnt", 32'(data_gnt_o), 32'd0);
      step();
    end
    bus_gnt_i = 1;
    @(negedge clk_i);
    chk("lock_instr_gnt", 32'(instr_gnt_o), 32'd1);
    chk("lock_data_gnt_c3", 32'(data_gnt_o), 32'd0);
    exp_i.push_back(32'h44);
    step();
    instr_req_i = 0; bus_gnt_i = 1; bus_rvalid_i = 1; bus_rdata_i = 32'h44;
    @(negedge clk_i);
    chk("lock_resp_no_gnt", 32'(data_gnt_o), 32'd0);
    step();
    bus_rvalid_i = 0;
    @(negedge clk_i);
    chk("lock_data_after", 32'(data_gnt_o), 32'd1);
    chk("lock_data_addr", bus_addr_o, 32'h500);
    exp_d.push_back(32'h55);
    step();
    data_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h55;
    @(negedge clk_i);
    step();
    clear_inputs();
    step();

    // Reset while a response is outstanding; late rvalid must be dropped.
    instr_req_i = 1; instr_addr_i = 32'h600; bus_gnt_i = 1;
    @(negedge clk_i);
    chk("rst_pre_gnt", 32'(instr_gnt_o), 32'd1);
    step();
    instr_req_i = 0; bus_gnt_i = 0; rst_i = 1;
    @(negedge clk_i);
    chk("rst_mid_outs", outs_vec(), 32'd0);
    step();
    rst_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h55;
    instr_req_i = 1; data_req_i = 1; bus_gnt_i = 1;
    @(negedge clk_i);
    chk("rst_after_outs", outs_vec(), 32'd0);
    chk("rst_after_addr", bus_addr_o, 32'd0);
    step();
    clear_inputs();
    step();

    // Randomized traffic against a memory reference model.
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    bpend = 0; bdly = 0; bdata = 0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      raise = (cyc < 400);
      @(negedge clk_i);
      gi = instr_gnt_o; gd = data_gnt_o;
      if (bus_req_o && bus_gnt_i) begin
        idx = bus_addr_o[7:2];
        if (bus_we_o != 0) begin
          bus_mem[idx] = merge(bus_mem[idx], bus_wdata_o, bus_we_o);
          bdata = 0;
        end else bdata = bus_mem[idx];
        bpend = 1; bdly = $urandom_range(0, 2);
        chk("rnd_one_gnt", 32'(gi) + 32'(gd), 32'd1);
      end else if (gi || gd) chk("rnd_spurious_gnt", {30'd0, gi, gd}, 32'd0);
      if (gi) begin
        chk("rnd_instr_addr", bus_addr_o, instr_addr_i);
        chk("rnd_instr_we", 32'(bus_we_o), 32'd0);
        chk("rnd_instr_wdata", bus_wdata_o, 32'd0);
        exp_i.push_back(ref_mem[instr_addr_i[7:2]]);
      end
      if (gd) begin
        chk("rnd_data_addr", bus_addr_o, data_addr_i);
        chk("rnd_data_we", 32'(bus_we_o), 32'(data_we_i));
        chk("rnd_data_wdata", bus_wdata_o, data_wdata_i);
        if (data_we_i != 0) begin
          ref_mem[data_addr_i[7:2]] = merge(ref_mem[data_addr_i[7:2]], data_wdata_i, data_we_i);
          exp_d.push_back(32'd0);
        end else exp_d.push_back(ref_mem[data_addr_i[7:2]]);
      end
      step();
      if (gi) instr_req_i = 0;
      if (gd) data_req_i = 0;
      if (!instr_req_i && raise && $urandom_range(0, 1) == 1) begin
        instr_req_i = 1; instr_addr_i = {24'd0, 6'($urandom), 2'b00};
      end
      if (!data_req_i && raise && $urandom_range(0, 1) == 1) begin
        data_req_i = 1; data_addr_i = {24'd0, 6'($urandom), 2'b00};
        data_we_i = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        data_wdata_i = $urandom;
      end
      bus_gnt_i = ($urandom_range(0, 2) != 0);
      if (bpend) begin
        if (bdly == 0) begin bus_rvalid_i = 1; bus_rdata_i = bdata; bpend = 0; end
        else begin bus_rvalid_i = 0; bdly--; end
      end else begin
        bus_rvalid_i = ($urandom_range(0, 7) == 0);
        bus_rdata_i = $urandom;
      end
    end
    chk("rnd_drain_instr_q", 32'(exp_i.size()), 32'd0);
    chk("rnd_drain_data_q", 32'(exp_d.size()), 32'd0);
    chk("rnd_drain_reqs", {30'd0, instr_req_i, data_req_i}, 32'd0);

`ifdef PANDA_ARB_PERF_EN
    do_reset();
    chk("perf_instr_rst", perf_instr_cnt_o, 32'd0);
    chk("perf_data_rst", perf_data_cnt_o, 32'd0);
    chk("perf_stall_rst", perf_stall_cnt_o, 32'd0);
    for (int k = 0; k < 3; k++) txn(0, 32'h40 + 32'(k * 4), 4'h0, 32'h0, 32'h1000 + 32'(k));
    for (int k = 0; k < 2; k++) txn(1, 32'h80 + 32'(k * 4), 4'h0, 32'h0, 32'h2000 + 32'(k));
    @(negedge clk_i);
    chk("perf_data_cnt", perf_data_cnt_o, 32'd3);
    chk("perf_instr_cnt", perf_instr_cnt_o, 32'd2);
    do_reset();
    chk("perf_instr_rst2", perf_instr_cnt_o, 32'd0);
    chk("perf_data_rst2", perf_data_cnt_o, 32'd0);
    chk("perf_stall_rst2", perf_stall_cnt_o, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/panda_mem_arbiter.md
Name:
panda_mem_arbiter

Overview:
- Shares one memory bus between the instruction fetch port (IF stage) and the data port (MEM stage) of panda_core.
- Uses a req/gnt/rvalid handshake with one transaction outstanding at a time.
- Data wins by default; a starvation counter forces an instruction grant after a bounded wait.
- Sits between the core's instr_*/data_* ports and a unified single-port memory or bus.

Parameters:
STARVE_LIMIT, 4, consecutive cycles instr may wait with request pending before it wins arbitration; legal range 1..255

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
instr_req_i  input  1  fetch request; held with addr until instr_gnt_o
instr_addr_i  input  32  fetch address
instr_gnt_o  output  1  fetch request accepted by bus this cycle
instr_rvalid_o  output  1  fetch read data valid
instr_rdata_o  output  32  fetch read data
data_req_i  input  1  load/store request; held with addr/we/wdata until data_gnt_o
data_addr_i  input  32  data address
data_we_i  input  4  byte write enables; 0 = load
data_wdata_i  input  32  store data
data_gnt_o  output  1  data request accepted this cycle
data_rvalid_o  output  1  data response valid (loads and stores)
data_rdata_o  output  32  load data
bus_req_o  output  1  bus request
bus_addr_o  output  32  bus address
bus_we_o  output  4  bus byte enables; 0 for fetches
bus_wdata_o  output  32  bus write data; 0 for fetches
bus_gnt_i  input  1  bus accepted request
bus_rvalid_i  input  1  bus response valid, exactly one per granted request
bus_rdata_i  input  32  bus response data

Behaviour:
- Reset value of every registered item: state IDLE, locked=0, lock_owner=DATA, resp_owner=DATA, starve_cnt=0.
- All outputs are 0 in reset and in the cycle after reset.
- States: IDLE, RESP. State type arb_state_e; owner type arb_owner_e {OWN_INSTR, OWN_DATA}.
- Winner, combinational in IDLE:
  - if locked: winner=lock_owner;
  - else if instr_req_i && (!data_req_i || starve_cnt==STARVE_LIMIT): winner=OWN_INSTR;
  - else: winner=OWN_DATA.
- IDLE request path:
  - bus_req_o = request of the winner.
  - bus_addr_o, bus_we_o and bus_wdata_o are muxed from the winner; instr forces we=0 and wdata=0.
  - The winner's gnt_o = bus_gnt_i; the other requester's gnt_o = 0.
- IDLE, bus_req_o && !bus_gnt_i: locked<=1 and lock_owner<=winner. The owner cannot change mid-handshake, even if the other requester's priority rises.
- IDLE, bus_req_o && bus_gnt_i: locked<=0, resp_owner<=winner, state<=RESP. This gives zero-cycle issue latency.
- RESP:
  - bus_req_o=0 and both gnt_o=0.
  - On bus_rvalid_i: resp_owner's rvalid_o=1 and rdata_o=bus_rdata_i, then state<=IDLE.
  - Minimum cadence is 2 cycles per transaction.
- rdata_o equals bus_rdata_i when rvalid_o=1 and is 0 otherwise. The non-owner's rvalid_o is always 0.
- starve_cnt:
  - Increments each cycle instr_req_i=1 && instr_gnt_o=0, saturating at STARVE_LIMIT.
  - Clears on instr_gnt_o=1, or when instr_req_i=0.
  - Width is $clog2(STARVE_LIMIT+1).
- Boundary conditions:
  - bus_rvalid_i in IDLE is ignored (no rvalid_o).
  - bus_gnt_i in RESP is ignored.
  - Both requests in the same cycle with starve_cnt<STARVE_LIMIT: data wins.
- Reset mid-transaction: state returns to IDLE and the outstanding response is dropped. Any later stray rvalid is ignored per the IDLE rule.

Optional Feature:
PANDA_ARB_PERF_EN
- Defined: adds output ports perf_instr_cnt_o[31:0], perf_data_cnt_o[31:0] and perf_stall_cnt_o[31:0].
  - perf_instr_cnt_o and perf_data_cnt_o count grants per requester.
  - perf_stall_cnt_o counts cycles where any req_i=1 and its gnt_o=0.
  - All three reset to 0 on rst_i and wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- panda_pkg gains:
  - arb_state_e {ARB_IDLE, ARB_RESP}
  - arb_owner_e {OWN_INSTR, OWN_DATA}
  - ARB_STARVE_LIMIT_DEFAULT = 4
- One sub-module, panda_arb_starve_cnt: a saturating counter with inc/clr/sat outputs, parameterised by STARVE_LIMIT.
- The FSM and muxes stay in panda_mem_arbiter.

Test Plan:
- Only instr_req_i=1, addr=0x100, bus_gnt_i=1 same cycle, rvalid next cycle with rdata=0xDEADBEEF:
  - instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 and instr_rdata_o=0xDEADBEEF in cycle 1; data_rvalid_o=0 throughout.
- Both req in the same cycle, data addr=0x200, we=4'hF, wdata=0x12345678:
  - bus_addr_o=0x200, bus_we_o=4'hF, data_gnt_o=1, instr_gnt_o=0.
- Data req held continuously, instr req held, bus always grants, rvalid 1 cycle after grant, STARVE_LIMIT=4:
  - instr granted no later than its 5th IDLE arbitration; starve_cnt returns to 0 after the grant.
- Instr wins, bus_gnt_i=0 for 3 cycles, data_req_i rises in cycle 1:
  - bus_addr_o stays the instr addr; data_gnt_o=0 until after the instr response.
- rst_i asserted during RESP, rvalid arrives 1 cycle after reset release:
  - all outputs 0 during and after reset; no rvalid_o pulse.
- PANDA_ARB_PERF_EN defined, 3 data grants + 2 instr grants:
  - perf_data_cnt_o=3, perf_instr_cnt_o=2; all three counters are 0 after rst_i.
